// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// The round-robin option is selected with the ARB_RR_EN macro (see arb_priority_sel).
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWNER_IFETCH,
    OWNER_DATA
  } arb_owner_t;

  localparam int unsigned ARB_MAX_LATENCY = 15;
  localparam int unsigned ARB_LAT_W       = $clog2(ARB_MAX_LATENCY + 1);

  typedef logic [ARB_LAT_W-1:0] lat_cnt_t;

  function automatic arb_owner_t arb_other(input arb_owner_t owner);
    return (owner == OWNER_IFETCH) ? OWNER_DATA : OWNER_IFETCH;
  endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// Combinational winner pick between the fetch and data requesters.
// ARB_RR_EN defined: alternate on contention; undefined: data always wins.
module arb_priority_sel
  import mem_arbiter_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_owner_t last_grant,
  output logic       grant_valid,
  output arb_owner_t winner
);

  assign grant_valid = i_req | d_req;

`ifdef ARB_RR_EN
  always_comb begin
    winner = OWNER_DATA;
    if (i_req && d_req) begin
      winner = arb_other(last_grant);
    end else if (i_req) begin
      winner = OWNER_IFETCH;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    winner = d_req ? OWNER_DATA : OWNER_IFETCH;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and data ports.
// Define ARB_RR_EN for round-robin arbitration; default is fixed data priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_done,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  arb_busy
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > ARB_MAX_LATENCY) begin : g_bad_latency
    $error("mem_arbiter: MEM_LATENCY must be in 1..15");
  end

  arb_state_t            state_q, state_d;
  arb_owner_t            owner_q, owner_d;
  arb_owner_t            last_grant_q, last_grant_d;
  lat_cnt_t              lat_cnt_q, lat_cnt_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic       grant_valid;
  arb_owner_t winner;

  arb_priority_sel u_sel (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant_q),
    .grant_valid(grant_valid),
    .winner     (winner)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    lat_cnt_d    = lat_cnt_q;
    we_d         = we_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          mem_en = 1'b1;
          if (winner == OWNER_DATA) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
          end else begin
            mem_addr = i_addr;
          end
          owner_d   = winner;
          we_d      = (winner == OWNER_DATA) && d_we;
          lat_cnt_d = lat_cnt_t'(MEM_LATENCY);
          state_d   = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        lat_cnt_d = lat_cnt_q - lat_cnt_t'(1);
        // Final busy cycle is T+MEM_LATENCY, exactly when mem_rdata is valid.
        if (lat_cnt_q == lat_cnt_t'(1)) begin
          if (owner_q == OWNER_IFETCH) begin
            i_rdata_d = mem_rdata;
          end else if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        last_grant_d = owner_q;
        state_d      = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWNER_DATA;
      last_grant_q <= OWNER_IFETCH;
      lat_cnt_q    <= '0;
      we_q         <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      lat_cnt_q    <= lat_cnt_d;
      we_q         <= we_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign i_done   = (state_q == ARB_RESP) && (owner_q == OWNER_IFETCH);
  assign d_done   = (state_q == ARB_RESP) && (owner_q == OWNER_DATA);
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign arb_busy = (state_q != ARB_IDLE);

  // The owning requester must keep req high until its done pulse.
  a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != ARB_IDLE) |-> ((owner_q == OWNER_DATA) ? d_req : i_req));

  a_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_done && d_done));

  a_en_idle_only: assert property (@(posedge clk) disable iff (!rst_n)
    mem_en |-> (state_q == ARB_IDLE));

endmodule
